// File: rtl/smart_home_multi.sv
// Smart-home controller: door/window/alarm Moore FSM with per-room
// hysteretic heater/cooler control. All outputs are registered.
module smart_home_multi #(
    parameter int ROOMS     = 4,
    parameter int TW        = 7,
    parameter int T_LOW     = 50,
    parameter int T_HIGH    = 60,
    parameter int HYST      = 2,
    parameter int DOOR_HOLD = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  SFD,
    input  logic                  SRD,
    input  logic [ROOMS-1:0]      SW,
    input  logic                  SFA,
    input  logic                  ACK,
    input  logic [ROOMS*TW-1:0]   ST,
    output logic                  fdoor,
    output logic                  rdoor,
    output logic                  winbuzz,
    output logic                  alarmbuzz,
    output logic [ROOMS-1:0]      win_mask,
    output logic [ROOMS-1:0]      heater,
    output logic [ROOMS-1:0]      cooler,
    output logic [2:0]            display
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_FDOOR  = 3'b001,
        S_RDOOR  = 3'b010,
        S_WINDOW = 3'b011,
        S_ALARM  = 3'b100
    } state_t;

    // Thresholds pre-cast to the temperature width so every compare is unsigned TW-bit.
    localparam logic [TW-1:0] L_LOW     = TW'(T_LOW);
    localparam logic [TW-1:0] L_LOW_HI  = TW'(T_LOW + HYST);
    localparam logic [TW-1:0] L_HIGH    = TW'(T_HIGH);
    localparam logic [TW-1:0] L_HIGH_LO = TW'(T_HIGH - HYST);
    localparam logic [7:0]    L_HOLD    = 8'(DOOR_HOLD);

    state_t           r_state;
    state_t           w_sel;
    state_t           w_next;
    logic [7:0]       r_hold;
    logic [7:0]       w_hold_nxt;
    logic [ROOMS-1:0] w_heat_nxt;
    logic [ROOMS-1:0] w_cool_nxt;
    logic [TW-1:0]    w_temp;

    // Highest-priority pending event, used whenever the FSM picks a fresh state.
    always_comb begin
        w_sel = S_IDLE;
        if (SFA) begin
            w_sel = S_ALARM;
        end else if (SFD) begin
            w_sel = S_FDOOR;
        end else if (SRD) begin
            w_sel = S_RDOOR;
        end else if (|SW) begin
            w_sel = S_WINDOW;
        end else begin
            w_sel = S_IDLE;
        end
    end

    // Next-state rules: alarm preempts everything, doors hold until their counter drains.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                w_next = w_sel;
            end
            S_FDOOR: begin
                if (SFA) begin
                    w_next = S_ALARM;
                end else if (SFD) begin
                    w_next = S_FDOOR;
                end else if (r_hold == 8'd0) begin
                    w_next = w_sel;
                end else begin
                    w_next = S_FDOOR;
                end
            end
            S_RDOOR: begin
                if (SFA) begin
                    w_next = S_ALARM;
                end else if (SFD) begin
                    w_next = S_FDOOR;
                end else if (SRD) begin
                    w_next = S_RDOOR;
                end else if (r_hold == 8'd0) begin
                    w_next = w_sel;
                end else begin
                    w_next = S_RDOOR;
                end
            end
            S_WINDOW: begin
                w_next = w_sel;
            end
            S_ALARM: begin
                if (ACK && !SFA) begin
                    w_next = w_sel;
                end else begin
                    w_next = S_ALARM;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Hold counter: reload on entry or while the door sensor is high, count down once it drops.
    always_comb begin
        w_hold_nxt = 8'd0;
        if (w_next == S_FDOOR) begin
            if ((r_state == S_FDOOR) && !SFD) begin
                w_hold_nxt = r_hold - 8'd1;
            end else begin
                w_hold_nxt = L_HOLD;
            end
        end else if (w_next == S_RDOOR) begin
            if ((r_state == S_RDOOR) && !SRD) begin
                w_hold_nxt = r_hold - 8'd1;
            end else begin
                w_hold_nxt = L_HOLD;
            end
        end else begin
            w_hold_nxt = 8'd0;
        end
    end

    // Per-room hysteresis; alarm or an open window clears the room so it restarts from off.
    always_comb begin
        w_heat_nxt = {ROOMS{1'b0}};
        w_cool_nxt = {ROOMS{1'b0}};
        w_temp     = {TW{1'b0}};
        for (int i = 0; i < ROOMS; i++) begin
            w_temp = ST[i*TW +: TW];
            if ((w_next == S_ALARM) || SW[i]) begin
                w_heat_nxt[i] = 1'b0;
                w_cool_nxt[i] = 1'b0;
            end else begin
                if (w_temp < L_LOW) begin
                    w_heat_nxt[i] = 1'b1;
                end else if (w_temp >= L_LOW_HI) begin
                    w_heat_nxt[i] = 1'b0;
                end else begin
                    w_heat_nxt[i] = heater[i];
                end
                if (w_temp > L_HIGH) begin
                    w_cool_nxt[i] = 1'b1;
                end else if (w_temp <= L_HIGH_LO) begin
                    w_cool_nxt[i] = 1'b0;
                end else begin
                    w_cool_nxt[i] = cooler[i];
                end
            end
        end
    end

    // State, hold counter and all actuator outputs, registered from the next-state decode.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state   <= S_IDLE;
            r_hold    <= 8'd0;
            fdoor     <= 1'b0;
            rdoor     <= 1'b0;
            winbuzz   <= 1'b0;
            alarmbuzz <= 1'b0;
            win_mask  <= {ROOMS{1'b0}};
            heater    <= {ROOMS{1'b0}};
            cooler    <= {ROOMS{1'b0}};
        end else begin
            r_state   <= w_next;
            r_hold    <= w_hold_nxt;
            fdoor     <= (w_next == S_FDOOR);
            rdoor     <= (w_next == S_RDOOR);
            winbuzz   <= (w_next == S_WINDOW);
            alarmbuzz <= (w_next == S_ALARM);
            win_mask  <= (w_next == S_WINDOW) ? SW : {ROOMS{1'b0}};
            heater    <= w_heat_nxt;
            cooler    <= w_cool_nxt;
        end
    end

    assign display = r_state;

endmodule

// File: doc/smart_home_multi.md
SMART_HOME_MULTI -- requirements
Module: smart_home_multi

Interface
REQ-001 SHALL have parameter ROOMS, default 4: number of rooms, legal range 1..8.
REQ-002 SHALL have parameter TW, default 7: per-room temperature width in bits, unsigned.
REQ-003 SHALL have parameter T_LOW, default 50: heater turn-on threshold.
REQ-004 SHALL have parameter T_HIGH, default 60: cooler turn-on threshold, with T_HIGH > T_LOW + 2*HYST.
REQ-005 SHALL have parameter HYST, default 2: hysteresis band.
REQ-006 SHALL have parameter DOOR_HOLD, default 8: cycles a door output stays open after its sensor drops, legal range 1..255.
REQ-007 Clk  in  1  sole clock; all state changes on the rising edge.
REQ-008 Rst  in  1  asynchronous, active-high reset.
REQ-009 SFD  in  1  front-door sensor.
REQ-010 SRD  in  1  rear-door sensor.
REQ-011 SW  in  ROOMS  per-room window-open sensors.
REQ-012 SFA  in  1  fire-alarm sensor.
REQ-013 ACK  in  1  alarm acknowledge.
REQ-014 ST  in  ROOMS*TW  packed temperatures; room i occupies bits [i*TW +: TW].
REQ-015 fdoor, rdoor, winbuzz, alarmbuzz  out  1 each  actuators.
REQ-016 win_mask  out  ROOMS  registered copy of SW while in WINDOW.
REQ-017 heater, cooler  out  ROOMS each  per-room climate actuators.
REQ-018 display  out  3  current state code.

Function
REQ-019 SHALL implement a Moore FSM with states IDLE=000, FDOOR=001, RDOOR=010, WINDOW=011, ALARM=100; display SHALL equal the state register.
REQ-020 Event priority SHALL be SFA > SFD > SRD > |SW. Events are sampled on edge k; the resulting state and outputs SHALL be visible after edge k (1-cycle latency).
REQ-021 From IDLE, the next state SHALL be the highest-priority active event, else IDLE.
REQ-022 SFA high in any state SHALL enter ALARM on the next edge, preempting door holds.
REQ-023 ALARM SHALL be latched and exit only on an edge where ACK=1 and SFA=0; the next state is then chosen as from IDLE.
REQ-024 FDOOR/RDOOR: the hold counter (8 bits) SHALL load DOOR_HOLD while the own sensor is high, and decrement while it is low.
REQ-025 The FSM SHALL leave FDOOR/RDOOR only when the counter is 0 and the sensor is low, using the IDLE selection rule; a higher-priority door event SHALL preempt a lower one.
REQ-026 A lower-priority event arriving during a hold SHALL wait, with no loss while it stays asserted.
REQ-027 WINDOW SHALL persist while |SW=1; win_mask SHALL update every cycle in WINDOW and be 0 elsewhere.
REQ-028 Output decode: fdoor=(FDOOR), rdoor=(RDOOR), winbuzz=(WINDOW), alarmbuzz=(ALARM).
REQ-029 Climate, per room i, registered: heater[i] SHALL set when T_i < T_LOW and clear when T_i >= T_LOW+HYST, holding otherwise.
REQ-030 Climate, per room i, registered: cooler[i] SHALL set when T_i > T_HIGH and clear when T_i <= T_HIGH-HYST, holding otherwise.
REQ-031 heater[i] and cooler[i] SHALL never be high together.
REQ-032 heater[i] and cooler[i] SHALL be forced 0 while in ALARM or while SW[i]=1; after the override ends, they SHALL re-evaluate from cleared state.
REQ-033 All comparisons SHALL be unsigned on TW bits, and T_LOW+HYST SHALL not overflow TW.

Reset
REQ-034 Rst=1 SHALL immediately force IDLE, display=000, the hold counter to 0, and all outputs to 0, independent of Clk.
REQ-035 Reset asserted mid-hold or mid-alarm SHALL discard the hold or latch; the first post-reset edge SHALL evaluate events as from IDLE.

Verification
REQ-036 SFD=1 for 3 cycles then 0 -> fdoor=1 from edge 1 through 8 edges after the fall, then display=000.
REQ-037 SRD=1 while SFD=1 -> display=001; after the front hold expires with SRD still 1 -> display=010.
REQ-038 SFA pulse during an FDOOR hold -> display=100 next edge; stays 100 after SFA=0 until ACK=1, then 000.
REQ-039 Room 2 temperature sweep 49,50,51,52 -> heater[2]=1,1,1,0; sweep 61,59,58 -> cooler[2]=1,1,0.
REQ-040 SW=4'b0101 with T0=40 -> display=011, win_mask=0101, heater[0]=0, heater[1] follows its own temperature.
REQ-041 Rst asserted asynchronously during ALARM -> all outputs 0 before the next Clk edge.
